// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address and enable out,
// synchronous read data back one cycle after an enabled read.
interface fetch_stage_if #(
    parameter int PCWIDTH    = 32,
    parameter int INSTRWIDTH = 32
) ();
    logic [PCWIDTH-1:0]    imemAddrF;
    logic                  imemEnF;
    logic [INSTRWIDTH-1:0] imemDataF;

    modport master (
        output imemAddrF,
        output imemEnF,
        input  imemDataF
    );

    modport slave (
        input  imemAddrF,
        input  imemEnF,
        output imemDataF
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, hides the one-cycle
// memory latency behind a one-entry skid buffer, and applies Execute redirects.
module fetch_stage #(
    parameter int                    PCWIDTH     = 32,
    parameter int                    INSTRWIDTH  = 32,
    parameter int                    OPCODEWIDTH = 4,
    parameter logic [PCWIDTH-1:0]    RESETPC     = 32'h0000_0000,
    parameter logic [PCWIDTH-1:0]    PCINCR      = 32'h0000_0004,
    parameter logic [INSTRWIDTH-1:0] BUBBLEINSTR = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stallF_i,
    input  logic                   branchTakenE_i,
    input  logic [PCWIDTH-1:0]     branchTargetE_i,
    fetch_stage_if.master          imem,
    output logic [INSTRWIDTH-1:0]  instrD_o,
    output logic [PCWIDTH-1:0]     pcD_o,
    output logic [OPCODEWIDTH-1:0] opcodeD_o,
    output logic                   validD_o
);

    logic [PCWIDTH-1:0]    pc_q,         pc_d;
    logic                  req_valid_q,  req_valid_d;
    logic [PCWIDTH-1:0]    req_pc_q,     req_pc_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [INSTRWIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [PCWIDTH-1:0]    hold_pc_q,    hold_pc_d;
    logic [INSTRWIDTH-1:0] instr_q,      instr_d;
    logic [PCWIDTH-1:0]    pcd_q,        pcd_d;
    logic                  valid_q,      valid_d;

    assign imem.imemAddrF = pc_q;
    assign imem.imemEnF   = !rst_i && !stallF_i && !branchTakenE_i;

    assign instrD_o  = instr_q;
    assign pcD_o     = pcd_q;
    assign validD_o  = valid_q;
    assign opcodeD_o = instr_q[INSTRWIDTH-1 -: OPCODEWIDTH];

    // Next-state selection: redirect beats stall beats advance.
    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        valid_d      = valid_q;

        if (branchTakenE_i) begin
            pc_d         = branchTargetE_i;
            req_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
            valid_d      = 1'b0;
            instr_d      = BUBBLEINSTR;
        end else if (stallF_i) begin
            // No read is issued while stalled, so the returning word is parked here.
            req_valid_d = 1'b0;
            if (req_valid_q && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_instr_d = imem.imemDataF;
                hold_pc_d    = req_pc_q;
            end else begin
                hold_valid_d = hold_valid_q;
            end
        end else begin
            if (hold_valid_q) begin
                instr_d = hold_instr_q;
                pcd_d   = hold_pc_q;
                valid_d = 1'b1;
            end else if (req_valid_q) begin
                instr_d = imem.imemDataF;
                pcd_d   = req_pc_q;
                valid_d = 1'b1;
            end else begin
                instr_d = BUBBLEINSTR;
                valid_d = 1'b0;
            end
            hold_valid_d = 1'b0;
            req_pc_d     = pc_q;
            req_valid_d  = 1'b1;
            pc_d         = pc_q + PCINCR;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESETPC;
            req_valid_q  <= 1'b0;
            req_pc_q     <= {PCWIDTH{1'b0}};
            hold_valid_q <= 1'b0;
            hold_instr_q <= BUBBLEINSTR;
            hold_pc_q    <= {PCWIDTH{1'b0}};
            instr_q      <= BUBBLEINSTR;
            pcd_q        <= {PCWIDTH{1'b0}};
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined processor. It owns the program counter, drives a synchronous-read instruction memory, absorbs the one-cycle memory latency with a one-entry skid buffer so stalls lose no instruction, and applies branch redirects from Execute. Its registered outputs feed the decode stage, where `opcodeD` drives the control unit and `pcD` supplies the PC operand for branch instructions (opcodes 1011–1111).

## Interface
- `PCWIDTH`, 32, width of PC and memory address.
- `INSTRWIDTH`, 32, instruction word width.
- `OPCODEWIDTH`, 4, opcode field width; the opcode is `instr[INSTRWIDTH-1 -: OPCODEWIDTH]`.
- `RESETPC`, 0, PC value loaded on reset.
- `PCINCR`, 4, sequential PC increment.
- `BUBBLEINSTR`, 0, value loaded into `instrD` when a bubble is inserted.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stallF`  in  1  hazard-unit stall; holds the PC and the IF/ID register.
- `branchTakenE`  in  1  redirect request from Execute.
- `branchTargetE`  in  PCWIDTH  redirect target.
- `imemAddrF`  out  PCWIDTH  instruction memory address; equals `pcF`.
- `imemEnF`  out  1  memory read enable; combinational.
- `imemDataF`  in  INSTRWIDTH  memory read data, valid one cycle after an enabled read.
- `instrD`  out  INSTRWIDTH  IF/ID instruction register.
- `pcD`  out  PCWIDTH  PC of `instrD`.
- `opcodeD`  out  OPCODEWIDTH  opcode field of `instrD`; combinational slice.
- `validD`  out  1  `instrD` is a real instruction; 0 means bubble.

## Operation
- State:
  - `pcF`: next fetch address.
  - `reqValid` and `reqPc`: a read was issued last cycle, and the PC it was issued for.
  - `holdValid`, `holdInstr`, `holdPc`: the skid buffer.
  - The IF/ID registers `instrD`, `pcD`, `validD`.
- `imemEnF = !rst && !stallF && !branchTakenE`.
- Per-cycle priority is rst > branchTakenE > stallF > advance.
- **Reset:**
  - `pcF`=RESETPC.
  - `reqValid`, `holdValid` and `validD` = 0.
  - `instrD`=BUBBLEINSTR; `pcD`=0.
- **Redirect** (`branchTakenE`=1, regardless of `stallF`):
  - `pcF`<=`branchTargetE`.
  - `reqValid`<=0 and `holdValid`<=0, so the in-flight and held instructions are discarded.
  - IF/ID gets a bubble: `validD`<=0, `instrD`<=BUBBLEINSTR. `pcD` holds.
- **Stall** (`stallF`=1, no redirect):
  - `pcF` and the IF/ID register hold.
  - No read is issued; `reqValid`<=0.
  - If `reqValid`=1 and `holdValid`=0, capture the returning data: `holdInstr`<=`imemDataF`, `holdPc`<=`reqPc`, `holdValid`<=1.
- **Advance:**
  - Select a source:
    - If `holdValid`=1, the source is the hold entry.
    - Else if `reqValid`=1, the source is `imemDataF` with `reqPc`.
    - Otherwise the source is a bubble.
  - Load IF/ID from the source. On a bubble, `validD`<=0 and `instrD`<=BUBBLEINSTR.
  - `holdValid`<=0.
  - Issue a read: `reqPc`<=`pcF`, `reqValid`<=1, `pcF`<=`pcF`+PCINCR.
- `holdValid` and `reqValid` are never both 1. This holds because no read is issued during a stall.
- PC arithmetic is modulo 2^PCWIDTH; `pcF`+PCINCR wraps silently.
- `opcodeD` is sliced from `instrD` regardless of `validD`. Decode must gate write enables with `validD`.

## Timing
- Reset values of all outputs:
  - `imemAddrF`=RESETPC.
  - `imemEnF`=0 while `rst` is high.
  - `instrD`=BUBBLEINSTR, `pcD`=0, `validD`=0.
  - `opcodeD` is the opcode field of BUBBLEINSTR.
- Startup: `rst` falls before edge E0.
  - A read of RESETPC is issued in the cycle before E0.
  - Data is available in the cycle after E0.
  - The instruction is loaded at E1; `validD`=1 after E1.
  - Steady state is one instruction per cycle.
- Stall: an N-cycle stall delays the stream by exactly N cycles, with no loss and no duplication.
- Redirect penalty:
  - Redirect at edge R; read of the target issued in the cycle after R.
  - Target instruction in IF/ID after edge R+2.
  - `validD`=0 for the two cycles following R.
- Redirect in the same cycle as `stallF`: the redirect wins.
- Redirect while `holdValid`=1: the hold entry is dropped.
- `rst` asserted mid-operation: at the next edge all state returns to reset values, and in-flight and held data are discarded.

## Test plan
- **Reset and startup:** hold `rst` 3 cycles, memory returns `mem[a]=a*16+1`.
  - Expected: `validD`=0 during reset.
  - Expected: the `pcD` sequence 0, 4, 8… with `validD`=1 from the 2nd cycle after release, and `instrD` matching.
- **One-cycle stall** while `pcD`=8:
  - Expected: `pcD` stays 8 one extra cycle.
  - Expected: the next values are 12, 16 with correct `instrD`; nothing skipped or repeated.
- **Four-cycle stall** immediately after startup:
  - Expected: `holdValid` captures `pcD`=0's successor.
  - Expected: the `pcD` sequence resumes contiguously.
  - Expected: `imemEnF`=0 for all four cycles.
- **Redirect to 0x100** while `pcD`=12:
  - Expected: `validD`=0 for 2 cycles.
  - Expected: then `pcD`=0x100, 0x104.
  - Expected: neither 16 nor 20 ever appears with `validD`=1.
- **Redirect to 0x40 in the same cycle as `stallF`,** with the skid buffer full:
  - Expected: the held entry is dropped.
  - Expected: `pcD`=0x40 is the next valid output, two cycles later.
- **Wraparound and mid-run reset:**
  - Redirect to 0xFFFFFFFC. Expected: `pcD`=0xFFFFFFFC then 0x0.
  - Assert `rst` for one cycle mid-stream. Expected: `validD`=0 next cycle, and the fetch restarts at RESETPC.
